// File: rtl/ysyx_23060236_tlb.sv
// ---------------------------------------------------------------------------
// ysyx_23060236_tlb
//
// Fully associative TLB for the MMU. Caches VPN->PPN pairs (Sv32 leaf PPN).
// A lookup is registered: tlb_hit / tlb_rdata show the result one cycle after
// tlb_rvalid and hold it until the next lookup. The MMU refills entries after
// a page walk. sfence.vma or a satp write invalidates everything through
// tlb_flush.
//
// Ports
//   clock       in   1      system clock
//   reset_n     in   1      asynchronous reset, active low
//   tlb_rvalid  in   1      lookup request this cycle
//   tlb_araddr  in   VPN_W  lookup VPN
//   tlb_hit     out  1      registered: last lookup hit
//   tlb_rdata   out  PPN_W  registered: PPN of hit entry, 0 on miss
//   tlb_wvalid  in   1      refill strobe, one cycle
//   tlb_awaddr  in   VPN_W  refill VPN
//   tlb_wdata   in   PPN_W  refill PPN
//   tlb_flush   in   1      invalidate all entries
//   perf_hit    out  32     (TLB_PERF_EN only) saturating lookup-hit count
//   perf_miss   out  32     (TLB_PERF_EN only) saturating lookup-miss count
//
// Build option: define TLB_PERF_EN to add the perf_hit/perf_miss counters.
// They are not cleared by tlb_flush.
// ---------------------------------------------------------------------------
module ysyx_23060236_tlb #(
   parameter int ENTRIES = 16,
   parameter int VPN_W   = 20,
   parameter int PPN_W   = 20
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             tlb_rvalid,
   input  logic [VPN_W-1:0] tlb_araddr,
   output logic             tlb_hit,
   output logic [PPN_W-1:0] tlb_rdata,
   input  logic             tlb_wvalid,
   input  logic [VPN_W-1:0] tlb_awaddr,
   input  logic [PPN_W-1:0] tlb_wdata,
   input  logic             tlb_flush
`ifdef TLB_PERF_EN
   ,
   output logic [31:0]      perf_hit,
   output logic [31:0]      perf_miss
`endif
);

   localparam int IDX_W = $clog2(ENTRIES);

   logic [ENTRIES-1:0] valid_q;
   logic [VPN_W-1:0]   vpn_q [ENTRIES];
   logic [PPN_W-1:0]   ppn_q [ENTRIES];
   logic [IDX_W-1:0]   victim_ptr;

   logic [ENTRIES-1:0] rd_match;
   logic               rd_hit;
   logic [PPN_W-1:0]   rd_ppn;

   logic               wr_match_any;
   logic [IDX_W-1:0]   wr_match_idx;
   logic               free_any;
   logic [IDX_W-1:0]   free_idx;
   logic [IDX_W-1:0]   wr_idx;
   logic               wr_evict;
   logic               wr_en;

   // Parallel lookup against every valid entry. Refill never creates
   // duplicate VPNs, so at most one entry matches and OR-ing the masked PPNs
   // selects it; with no match the result is naturally 0.
   always_comb begin
      rd_match = '0;
      rd_ppn   = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         rd_match[i] = valid_q[i] && (vpn_q[i] == tlb_araddr);
         if (rd_match[i]) begin
            rd_ppn = rd_ppn | ppn_q[i];
         end
      end
   end

   assign rd_hit = |rd_match;

   // Refill target selection. Scanning from the top down lets the lowest
   // index win both for an existing VPN match and for a free slot.
   always_comb begin
      wr_match_any = 1'b0;
      wr_match_idx = '0;
      free_any     = 1'b0;
      free_idx     = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (valid_q[i] && (vpn_q[i] == tlb_awaddr)) begin
            wr_match_any = 1'b1;
            wr_match_idx = IDX_W'(i);
         end
         if (!valid_q[i]) begin
            free_any = 1'b1;
            free_idx = IDX_W'(i);
         end
      end
   end

   // Priority: overwrite in place, else lowest free slot, else round-robin
   // victim. Only the victim case advances the pointer.
   always_comb begin
      wr_evict = 1'b0;
      if (wr_match_any) begin
         wr_idx = wr_match_idx;
      end else if (free_any) begin
         wr_idx = free_idx;
      end else begin
         wr_idx   = victim_ptr;
         wr_evict = 1'b1;
      end
   end

   // A flush drops any same-cycle refill.
   assign wr_en = tlb_wvalid && !tlb_flush;

   // Valid bits, victim pointer and the registered lookup result. Flush has
   // priority over a same-cycle lookup and refill. The pointer wraps
   // naturally because ENTRIES is a power of two.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         valid_q    <= '0;
         victim_ptr <= '0;
         tlb_hit    <= 1'b0;
         tlb_rdata  <= '0;
      end else if (tlb_flush) begin
         valid_q    <= '0;
         victim_ptr <= '0;
         tlb_hit    <= 1'b0;
         tlb_rdata  <= '0;
      end else begin
         if (tlb_rvalid) begin
            tlb_hit   <= rd_hit;
            tlb_rdata <= rd_ppn;
         end
         if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
            if (wr_evict) begin
               victim_ptr <= victim_ptr + IDX_W'(1);
            end
         end
      end
   end

   // Tag and data storage need no reset: an entry is only read while its
   // valid bit is set, and that bit is only set by a write here.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         vpn_q[wr_idx] <= tlb_awaddr;
         ppn_q[wr_idx] <= tlb_wdata;
      end
   end

`ifdef TLB_PERF_EN
   // Saturating hit/miss counters, bumped on the same edge that registers
   // the lookup result. A lookup during a flush is reported as a miss and
   // is counted as one.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         perf_hit  <= '0;
         perf_miss <= '0;
      end else if (tlb_rvalid) begin
         if (rd_hit && !tlb_flush) begin
            if (perf_hit != 32'hFFFF_FFFF) begin
               perf_hit <= perf_hit + 32'd1;
            end
         end else begin
            if (perf_miss != 32'hFFFF_FFFF) begin
               perf_miss <= perf_miss + 32'd1;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_ysyx_23060236_tlb.sv
// ---------------------------------------------------------------------------
// tb_ysyx_23060236_tlb
//
// Directed test of the TLB. The driver pushes the expected lookup result
// into a queue when it issues a lookup; a monitor pops and compares one
// cycle later, when the registered result is presented.
// ---------------------------------------------------------------------------
module tb_ysyx_23060236_tlb;

   typedef struct {
      logic        hit;
      logic [19:0] ppn;
      int          id;
   } exp_t;

   logic        clock;
   logic        reset_n;
   logic        tlb_rvalid;
   logic [19:0] tlb_araddr;
   logic        tlb_hit;
   logic [19:0] tlb_rdata;
   logic        tlb_wvalid;
   logic [19:0] tlb_awaddr;
   logic [19:0] tlb_wdata;
   logic        tlb_flush;
`ifdef TLB_PERF_EN
   logic [31:0] perf_hit;
   logic [31:0] perf_miss;
`endif

   exp_t exp_q[$];
   int   checks;
   int   passes;
   int   lookup_id;
   logic pend;

   ysyx_23060236_tlb #(
      .ENTRIES(16),
      .VPN_W  (20),
      .PPN_W  (20)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .tlb_rvalid(tlb_rvalid),
      .tlb_araddr(tlb_araddr),
      .tlb_hit   (tlb_hit),
      .tlb_rdata (tlb_rdata),
      .tlb_wvalid(tlb_wvalid),
      .tlb_awaddr(tlb_awaddr),
      .tlb_wdata (tlb_wdata),
      .tlb_flush (tlb_flush)
`ifdef TLB_PERF_EN
      ,
      .perf_hit  (perf_hit),
      .perf_miss (perf_miss)
`endif
   );

   // 10 time-unit clock.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Remember whether a lookup was accepted on the last edge; the result is
   // then on the outputs for the following negedge.
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) pend <= 1'b0;
      else          pend <= tlb_rvalid;
   end

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      checks++;
      if (act === exp) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: pop the expected lookup result and compare.
   always @(negedge clock) begin
      if (pend) begin
         if (exp_q.size() == 0) begin
            checks++;
            $display("[TB] FAIL unexpected_result: got hit=%0b, expected no pending lookup",
                     tlb_hit);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput($sformatf("lookup%0d_hit", e.id), {31'd0, tlb_hit}, {31'd0, e.hit});
            checkOutput($sformatf("lookup%0d_ppn", e.id), {12'd0, tlb_rdata}, {12'd0, e.ppn});
         end
      end
   end

   // Drive one cycle of inputs starting just after a posedge.
   task automatic applyStimulus(input logic rv, input logic [19:0] ra,
                                input logic wv, input logic [19:0] wa,
                                input logic [19:0] wd, input logic fl);
      tlb_rvalid = rv;
      tlb_araddr = ra;
      tlb_wvalid = wv;
      tlb_awaddr = wa;
      tlb_wdata  = wd;
      tlb_flush  = fl;
      @(posedge clock);
      #1;
      tlb_rvalid = 1'b0;
      tlb_wvalid = 1'b0;
      tlb_flush  = 1'b0;
   endtask

   task automatic expectLookup(input logic hit, input logic [19:0] ppn);
      exp_t e;
      e.hit = hit;
      e.ppn = ppn;
      e.id  = lookup_id;
      lookup_id++;
      exp_q.push_back(e);
   endtask

   task automatic lookup(input logic [19:0] vpn, input logic hit,
                         input logic [19:0] ppn);
      expectLookup(hit, ppn);
      applyStimulus(1'b1, vpn, 1'b0, 20'h0, 20'h0, 1'b0);
   endtask

   task automatic refill(input logic [19:0] vpn, input logic [19:0] ppn);
      applyStimulus(1'b0, 20'h0, 1'b1, vpn, ppn, 1'b0);
   endtask

   task automatic flush();
      applyStimulus(1'b0, 20'h0, 1'b0, 20'h0, 20'h0, 1'b1);
   endtask

   initial begin
      checks     = 0;
      passes     = 0;
      lookup_id  = 0;
      reset_n    = 1'b0;
      tlb_rvalid = 1'b0;
      tlb_araddr = '0;
      tlb_wvalid = 1'b0;
      tlb_awaddr = '0;
      tlb_wdata  = '0;
      tlb_flush  = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;

      // 1. reset state and a cold miss
      $display("[TB] reset and cold lookup");
      checkOutput("reset_hit", {31'd0, tlb_hit}, 32'd0);
      checkOutput("reset_rdata", {12'd0, tlb_rdata}, 32'd0);
      lookup(20'h12345, 1'b0, 20'h0);

      // 2. refill then hit, neighbour misses, in-place overwrite
      $display("[TB] refill and hit");
      refill(20'h12345, 20'h80001);
      lookup(20'h12345, 1'b1, 20'h80001);
      lookup(20'h12346, 1'b0, 20'h0);
      refill(20'h00020, 20'h11111);
      refill(20'h00020, 20'h22222);
      lookup(20'h00020, 1'b1, 20'h22222);

      // 3. same VPN twice uses one entry; 15 more fill without eviction
      $display("[TB] overwrite uses one entry");
      flush();
      refill(20'h00010, 20'h0AAAA);
      refill(20'h00010, 20'h0BBBB);
      lookup(20'h00010, 1'b1, 20'h0BBBB);
      for (int i = 0; i < 15; i++) begin
         refill(20'h00100 + 20'(i), 20'h05000 + 20'(i));
      end
      lookup(20'h00010, 1'b1, 20'h0BBBB);
      lookup(20'h00100, 1'b1, 20'h05000);
      lookup(20'h0010E, 1'b1, 20'h0500E);
      refill(20'h00300, 20'h05300);
      lookup(20'h00010, 1'b0, 20'h0);
      lookup(20'h00300, 1'b1, 20'h05300);
      lookup(20'h00100, 1'b1, 20'h05000);

      // 4. round-robin eviction when full
      $display("[TB] eviction");
      flush();
      for (int i = 0; i < 16; i++) begin
         refill(20'(i), 20'h01000 + 20'(i));
      end
      refill(20'd16, 20'h02010);
      lookup(20'd0, 1'b0, 20'h0);
      lookup(20'd16, 1'b1, 20'h02010);
      refill(20'd17, 20'h02011);
      lookup(20'd1, 1'b0, 20'h0);
      lookup(20'd2, 1'b1, 20'h01002);
      lookup(20'd17, 1'b1, 20'h02011);
      refill(20'd5, 20'h03005);
      refill(20'd18, 20'h02012);
      lookup(20'd2, 1'b0, 20'h0);
      lookup(20'd3, 1'b1, 20'h01003);
      lookup(20'd5, 1'b1, 20'h03005);
      // same-cycle lookup and refill of one VPN: no bypass
      expectLookup(1'b0, 20'h0);
      applyStimulus(1'b1, 20'h00400, 1'b1, 20'h00400, 20'h04400, 1'b0);
      lookup(20'h00400, 1'b1, 20'h04400);
      lookup(20'd3, 1'b0, 20'h0);

      // 5. flush beats same-cycle refill and lookup
      $display("[TB] flush priority");
      flush();
      for (int i = 1; i <= 4; i++) begin
         refill(20'(i), 20'h00600 + 20'(i));
      end
      lookup(20'd1, 1'b1, 20'h00601);
      expectLookup(1'b0, 20'h0);
      applyStimulus(1'b1, 20'h00001, 1'b1, 20'h00099, 20'h00999, 1'b1);
      for (int i = 1; i <= 4; i++) begin
         lookup(20'(i), 1'b0, 20'h0);
      end
      lookup(20'h00099, 1'b0, 20'h0);

      // 6. asynchronous reset mid-operation
      $display("[TB] async reset");
      refill(20'h00700, 20'h07777);
      lookup(20'h00700, 1'b1, 20'h07777);
      @(negedge clock);
      #1;
      checkOutput("prereset_hit", {31'd0, tlb_hit}, 32'd1);
      reset_n = 1'b0;
      #1;
      checkOutput("async_reset_hit", {31'd0, tlb_hit}, 32'd0);
      checkOutput("async_reset_rdata", {12'd0, tlb_rdata}, 32'd0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      lookup(20'h00700, 1'b0, 20'h0);
      refill(20'h00700, 20'h07777);
      lookup(20'h00700, 1'b1, 20'h07777);
      lookup(20'h00700, 1'b1, 20'h07777);
      lookup(20'h00700, 1'b1, 20'h07777);
      lookup(20'h00701, 1'b0, 20'h0);
      @(negedge clock);
`ifdef TLB_PERF_EN
      checkOutput("perf_hit", perf_hit, 32'd3);
      checkOutput("perf_miss", perf_miss, 32'd2);
`endif

      // drain the scoreboard with a bounded wait
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
         @(posedge clock);
      end
      if (exp_q.size() != 0) begin
         checks++;
         $display("[TB] FAIL drain: got %0d lookups outstanding, expected 0",
                  exp_q.size());
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
